// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the pipelined data memory
`ifndef DMEM_PKG_SV
`define DMEM_PKG_SV

// Response record; width follows the instantiating module's DATA_W.
`define DMEM_RSP_T(W) struct packed { logic valid; logic err; logic [(W)-1:0] rdata; }

package dmem_pkg;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } dmemState_e;

endpackage

`endif

// File: rtl/dmem_rsp_pipe.sv
// rtl/dmem_rsp_pipe.sv - fixed-latency in-order response delay line
module dmem_rsp_pipe #(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W+1:0] rspIn,
    output logic [DATA_W+1:0] rspOut
);

    typedef `DMEM_RSP_T(DATA_W) rsp_t;

    rsp_t stage [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= rsp_t'(rspIn);
            for (int i = 1; i < RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign rspOut = stage[RD_LAT-1];

endmodule

// File: rtl/data_memory_pipe.sv
// rtl/data_memory_pipe.sv - word-indexed data memory with byte lanes and pipelined responses
module data_memory_pipe
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_rw,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CLR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Wide enough for both the full address and DEPTH, so nothing is truncated before the range test.
    localparam int CMP_W = (ADDR_W > 32) ? ADDR_W + 1 : 33;

    typedef `DMEM_RSP_T(DATA_W) rsp_t;

    dmemState_e        state;
    dmemState_e        nextState;
    logic [CLR_W-1:0]  clrCnt;
    logic              clrLast;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [CMP_W-1:0]  addrExt;
    logic              addrOk;
    logic [CLR_W-1:0]  wordIdx;
    logic              accept;
    rsp_t              rspIn;
    rsp_t              rspOut;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        if (state == ST_INIT && clrLast) begin
            nextState = ST_RUN;
        end
    end

    always_comb begin
        req_ready = (state == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clrCnt <= '0;
        end else if (state == ST_INIT) begin
            clrCnt <= clrCnt + CLR_W'(1);
        end
    end

    assign clrLast = (clrCnt == CLR_W'(DEPTH - 1));
    assign addrExt = CMP_W'(req_addr);
    assign addrOk  = (addrExt < CMP_W'(DEPTH));
    assign wordIdx = CLR_W'(addrExt);
    assign accept  = req_valid && req_ready;

    // The array has no reset; INIT sweeps it to zero one word per cycle.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[clrCnt] <= '0;
        end else if (accept && req_rw == RW_WRITE && addrOk) begin
            for (int k = 0; k < BE_W; k++) begin
                if (req_be[k]) begin
                    mem[wordIdx][8*k +: 8] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        rspIn       = '0;
        rspIn.valid = accept;
        rspIn.err   = accept && !addrOk;
        if (accept && addrOk && req_rw == RW_READ) begin
            rspIn.rdata = mem[wordIdx];
        end
    end

    dmem_rsp_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) uRspPipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .rspIn  (rspIn),
        .rspOut (rspOut)
    );

    assign rsp_valid = rspOut.valid;
    assign rsp_err   = rspOut.err;
    assign rsp_rdata = rspOut.rdata;

endmodule

// File: tb/tb_data_memory_pipe.sv
// tb/tb_data_memory_pipe.sv - directed bench for data_memory_pipe at read latencies 2 and 4
module tb_data_memory_pipe;

    localparam int LAT_A = 2;
    localparam int LAT_B = 4;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reqValid;
    logic        reqRw;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic [3:0]  reqBe;
    logic        reqReadyA, rspValidA, rspErrA;
    logic        reqReadyB, rspValidB, rspErrB;
    logic [31:0] rspRdataA, rspRdataB;

    int   cyc = 0;
    int   nChecks = 0;
    int   nErrors = 0;
    exp_t qA[$];
    exp_t qB[$];
    exp_t eA, eB;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_pipe #(.DATA_W(32), .DEPTH(512), .ADDR_W(32), .RD_LAT(LAT_A)) dutA (
        .clk(clk), .rst_n(rst_n), .req_valid(reqValid), .req_ready(reqReadyA),
        .req_rw(reqRw), .req_addr(reqAddr), .req_wdata(reqWdata), .req_be(reqBe),
        .rsp_valid(rspValidA), .rsp_rdata(rspRdataA), .rsp_err(rspErrA)
    );

    data_memory_pipe #(.DATA_W(32), .DEPTH(512), .ADDR_W(32), .RD_LAT(LAT_B)) dutB (
        .clk(clk), .rst_n(rst_n), .req_valid(reqValid), .req_ready(reqReadyB),
        .req_rw(reqRw), .req_addr(reqAddr), .req_wdata(reqWdata), .req_be(reqBe),
        .rsp_valid(rspValidB), .rsp_rdata(rspRdataB), .rsp_err(rspErrB)
    );

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the request is accepted at the following posedge.
    task automatic doReq(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] expData, input logic expErr);
        exp_t e;
        reqValid = 1'b1;
        reqRw    = rw;
        reqAddr  = addr;
        reqWdata = wdata;
        reqBe    = be;
        checkEq("readyA_at_req", reqReadyA, 1);
        checkEq("readyB_at_req", reqReadyB, 1);
        e.rdata = expData;
        e.err   = expErr;
        e.due   = cyc + LAT_A;
        qA.push_back(e);
        e.due   = cyc + LAT_B;
        qB.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        reqValid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic waitReady();
        int n = 0;
        while (!reqReadyA && n < 2000) begin
            @(negedge clk);
            n++;
        end
        reqValid = 1'b0;
        checkEq("init_cycles", n, 512);
        checkEq("readyB_after_init", reqReadyB, 1);
    endtask

    always @(posedge clk) begin
        #1;
        if (rspValidA) begin
            if (qA.size() == 0) begin
                checkEq("A_spurious_rsp", rspValidA, 0);
            end else begin
                eA = qA.pop_front();
                checkEq("A_rsp_cycle", cyc, eA.due);
                checkEq("A_rdata", rspRdataA, eA.rdata);
                checkEq("A_err", rspErrA, eA.err);
            end
        end else begin
            checkEq("A_idle_zero", {rspErrA, rspRdataA}, 0);
            if (qA.size() != 0 && qA[0].due <= cyc) begin
                checkEq("A_missing_rsp", rspValidA, 1);
                void'(qA.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rspValidB) begin
            if (qB.size() == 0) begin
                checkEq("B_spurious_rsp", rspValidB, 0);
            end else begin
                eB = qB.pop_front();
                checkEq("B_rsp_cycle", cyc, eB.due);
                checkEq("B_rdata", rspRdataB, eB.rdata);
                checkEq("B_err", rspErrB, eB.err);
            end
        end else begin
            checkEq("B_idle_zero", {rspErrB, rspRdataB}, 0);
            if (qB.size() != 0 && qB[0].due <= cyc) begin
                checkEq("B_missing_rsp", rspValidB, 1);
                void'(qB.pop_front());
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        // A write held on the bus through reset and INIT must never land.
        reqValid = 1'b1;
        reqRw    = 1'b1;
        reqAddr  = 32'd3;
        reqWdata = 32'hFFFF_FFFF;
        reqBe    = 4'hF;
        repeat (3) @(negedge clk);
        checkEq("rst_readyA", reqReadyA, 0);
        checkEq("rst_readyB", reqReadyB, 0);
        checkEq("rst_rspA", {rspValidA, rspErrA, rspRdataA}, 0);
        checkEq("rst_rspB", {rspValidB, rspErrB, rspRdataB}, 0);
        rst_n = 1'b1;
        waitReady();

        doReq(1'b0, 32'd0,   32'h0, 4'h0, 32'h0, 1'b0);
        doReq(1'b0, 32'd255, 32'h0, 4'h0, 32'h0, 1'b0);
        doReq(1'b0, 32'd511, 32'h0, 4'h0, 32'h0, 1'b0);
        doReq(1'b0, 32'd3,   32'h0, 4'h0, 32'h0, 1'b0);
        idle(2);

        doReq(1'b1, 32'd5, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        doReq(1'b0, 32'd5, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);
        doReq(1'b1, 32'd5, 32'h1122_3344, 4'b0101, 32'h0, 1'b0);
        doReq(1'b0, 32'd5, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0);
        doReq(1'b1, 32'd5, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
        doReq(1'b0, 32'd5, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0);
        idle(3);

        doReq(1'b1, 32'd0,         32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0);
        doReq(1'b0, 32'd512,       32'h0,         4'h0, 32'h0, 1'b1);
        doReq(1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 4'hF, 32'h0, 1'b1);
        doReq(1'b1, 32'd512,       32'h5555_5555, 4'hF, 32'h0, 1'b1);
        doReq(1'b1, 32'h8000_0000, 32'h7777_7777, 4'hF, 32'h0, 1'b1);
        doReq(1'b0, 32'd0,         32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0);
        doReq(1'b0, 32'd511,       32'h0,         4'h0, 32'h0, 1'b0);
        doReq(1'b0, 32'hFFFF_FFFF, 32'h0,         4'h0, 32'h0, 1'b1);
        idle(5);

        for (int k = 0; k < 8; k++) begin
            doReq(1'b1, k, k, 4'hF, 32'h0, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            doReq(1'b0, k, 32'h0, 4'h0, k, 1'b0);
        end
        idle(6);
        checkEq("A_queue_drained", qA.size(), 0);
        checkEq("B_queue_drained", qB.size(), 0);

        doReq(1'b1, 32'd9, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
        idle(5);
        doReq(1'b0, 32'd9, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
        doReq(1'b0, 32'd5, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);
        reqValid = 1'b0;
        rst_n    = 1'b0;
        qA.delete();
        qB.delete();
        #1;
        checkEq("midrst_validA", rspValidA, 0);
        checkEq("midrst_validB", rspValidB, 0);
        checkEq("midrst_readyA", reqReadyA, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        waitReady();
        doReq(1'b0, 32'd9, 32'h0, 4'h0, 32'h0, 1'b0);
        doReq(1'b0, 32'd5, 32'h0, 4'h0, 32'h0, 1'b0);
        doReq(1'b0, 32'd7, 32'h0, 4'h0, 32'h0, 1'b0);
        idle(6);
        checkEq("A_queue_final", qA.size(), 0);
        checkEq("B_queue_final", qB.size(), 0);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
